// File: rtl/spu_pkg.sv
// SPU instruction-set helpers shared by the issue/route stage and decode.
// Instruction bits use big-endian numbering [0:31]; opcode fields sit at the top.
package spu_pkg;

  localparam int unsigned WORD  = 32;
  localparam int unsigned REG_W = 7;

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pipe_t;
  typedef enum logic {PAIR = 1'b0, SPLIT = 1'b1} route_state_t;

  typedef logic [REG_W-1:0] reg_t;

  // vld[2] = RA, vld[1] = RB, vld[0] = RC (RC also carries the stored RT of STQD)
  typedef struct packed {
    logic [2:0] vld;
    reg_t       ra;
    reg_t       rb;
    reg_t       rc;
  } srcs_t;

  typedef enum logic [3:0] {
    OP_UNK, OP_NOP, OP_LNOP, OP_A, OP_SF, OP_OR, OP_LQX,
    OP_AI, OP_LQD, OP_STQD, OP_SELB
  } op_t;

  // RR-format (11-bit) opcodes
  localparam logic [0:10] NOP  = 11'h201;
  localparam logic [0:10] LNOP = 11'h001;
  localparam logic [0:10] A    = 11'h0C0;
  localparam logic [0:10] SF   = 11'h040;
  localparam logic [0:10] OR   = 11'h041;
  localparam logic [0:10] LQX  = 11'h1C4;
  // RI10-format (8-bit) opcodes
  localparam logic [0:7]  LQD  = 8'h34;
  localparam logic [0:7]  STQD = 8'h24;
  localparam logic [0:7]  AI   = 8'h1C;
  // RRR-format (4-bit) opcodes
  localparam logic [0:3]  SELB = 4'h8;

  function automatic op_t op_of(input logic [0:WORD-1] i);
    op_t op;
    op = OP_UNK;
    if (i[0:3] == SELB) begin
      op = OP_SELB;
    end else begin
      case (i[0:7])
        LQD:     op = OP_LQD;
        STQD:    op = OP_STQD;
        AI:      op = OP_AI;
        default: begin
          case (i[0:10])
            NOP:     op = OP_NOP;
            LNOP:    op = OP_LNOP;
            A:       op = OP_A;
            SF:      op = OP_SF;
            OR:      op = OP_OR;
            LQX:     op = OP_LQX;
            default: op = OP_UNK;
          endcase
        end
      endcase
    end
    return op;
  endfunction

  function automatic pipe_t pipe_of(input logic [0:WORD-1] i);
    case (op_of(i))
      OP_LNOP, OP_LQX, OP_LQD, OP_STQD: return ODD;
      default:                          return EVEN;
    endcase
  endfunction

  function automatic logic writes_rt(input logic [0:WORD-1] i);
    case (op_of(i))
      OP_UNK, OP_NOP, OP_LNOP, OP_STQD: return 1'b0;
      default:                          return 1'b1;
    endcase
  endfunction

  function automatic reg_t rt_of(input logic [0:WORD-1] i);
    return (op_of(i) == OP_SELB) ? i[4:10] : i[25:31];
  endfunction

  function automatic srcs_t srcs_of(input logic [0:WORD-1] i);
    srcs_t s;
    s.ra = i[18:24];
    s.rb = i[11:17];
    s.rc = i[25:31];
    case (op_of(i))
      OP_A, OP_SF, OP_OR, OP_LQX: s.vld = 3'b110;
      OP_AI, OP_LQD:              s.vld = 3'b100;
      OP_STQD:                    s.vld = 3'b101;
      OP_SELB:                    s.vld = 3'b111;
      default:                    s.vld = 3'b000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational classification of one instruction: pipe, destination and sources.
module instr_classify
  import spu_pkg::*;
(
  input  logic [0:WORD-1] instr,
  output pipe_t           pipe,
  output logic            wr,
  output reg_t            rt,
  output srcs_t           srcs
);

  always_comb begin
    pipe = pipe_of(instr);
    wr   = writes_rt(instr);
    rt   = rt_of(instr);
    srcs = srcs_of(instr);
  end

endmodule

// File: rtl/dual_issue_route.sv
// Issue/route stage: dual-issues an even/odd pair when legal, otherwise splits it
// over two cycles using a one-entry hold register and back-pressures fetch.
module dual_issue_route
  import spu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop_and_signal,
  input  logic             branch_taken,
  input  logic             hazard_stall,
  input  logic             fetch_valid,
  input  logic [0:WORD-1]  instr1,
  input  logic [0:WORD-1]  instr2,
  output logic             dep_stall_instr1,
  output logic             dep_stall_instr2,
  output logic [0:WORD-1]  even_instr,
  output logic             even_valid,
  output logic [0:WORD-1]  odd_instr,
  output logic             odd_valid,
  output logic [CNT_W-1:0] dual_count
);

  route_state_t    state;
  logic [0:WORD-1] hold;
  pipe_t           hold_pipe;

  pipe_t pipe1, pipe2;
  logic  wr1, wr2;
  reg_t  rt1, rt2;
  srcs_t srcs1, srcs2;

  logic raw, dual_ok, freeze, split_now;
  logic unused_fields;

  instr_classify u_cls1 (.instr(instr1), .pipe(pipe1), .wr(wr1), .rt(rt1), .srcs(srcs1));
  instr_classify u_cls2 (.instr(instr2), .pipe(pipe2), .wr(wr2), .rt(rt2), .srcs(srcs2));

  // Only instr1's destination and instr2's sources matter for the RAW check
  assign unused_fields = ^{wr2, rt2, srcs1};

  always_comb begin
    raw = wr1 && ((srcs2.vld[2] && (srcs2.ra == rt1)) ||
                  (srcs2.vld[1] && (srcs2.rb == rt1)) ||
                  (srcs2.vld[0] && (srcs2.rc == rt1)));
    dual_ok   = (pipe1 == EVEN) && (pipe2 == ODD) && !raw;
    freeze    = stop_and_signal || hazard_stall;
    split_now = (state == PAIR) && fetch_valid && !dual_ok;
    // A taken branch must let fetch load the target, so it overrides every stall
    dep_stall_instr1 = !branch_taken && freeze;
    dep_stall_instr2 = !branch_taken && (freeze || split_now);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PAIR;
      hold       <= '0;
      hold_pipe  <= EVEN;
      even_instr <= '0;
      odd_instr  <= '0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      dual_count <= '0;
    end else if (branch_taken) begin
      state      <= PAIR;
      hold       <= '0;
      hold_pipe  <= EVEN;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
    end else if (freeze) begin
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
    end else begin
      case (state)
        SPLIT: begin
          even_valid <= (hold_pipe == EVEN);
          odd_valid  <= (hold_pipe == ODD);
          if (hold_pipe == EVEN) even_instr <= hold;
          else                   odd_instr  <= hold;
          hold  <= '0;
          state <= PAIR;
        end
        default: begin
          if (!fetch_valid) begin
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
          end else if (dual_ok) begin
            even_instr <= instr1;
            odd_instr  <= instr2;
            even_valid <= 1'b1;
            odd_valid  <= 1'b1;
            dual_count <= dual_count + CNT_W'(1);
          end else begin
            // instr1 goes now on its own pipe; instr2 waits one cycle in hold
            even_valid <= (pipe1 == EVEN);
            odd_valid  <= (pipe1 == ODD);
            if (pipe1 == EVEN) even_instr <= instr1;
            else               odd_instr  <= instr1;
            hold      <= instr2;
            hold_pipe <= pipe2;
            state     <= SPLIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_issue_route.sv
// Randomized bench for dual_issue_route with a behavioural pairing model and
// directed scenarios pinned by literal expectations.
module tb_dual_issue_route;

  logic        clk = 1'b0;
  logic        reset, stop_and_signal, branch_taken, hazard_stall, fetch_valid;
  logic [31:0] instr1, instr2;
  logic        dep_stall_instr1, dep_stall_instr2;
  logic [31:0] even_instr, odd_instr;
  logic        even_valid, odd_valid;
  logic [31:0] dual_count;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit          m_split = 1'b0;
  logic [31:0] m_held  = '0;
  bit          e_ev_v, e_od_v, e_s1, e_s2, last_stall;
  logic [31:0] e_ev, e_od, e_cnt;

  localparam logic [31:0] I_A3    = 32'h18008083; // a $3,$1,$2
  localparam logic [31:0] I_LQD5  = 32'h34000205; // lqd $5,0($4)
  localparam logic [31:0] I_LQD53 = 32'h34000185; // lqd $5,0($3)
  localparam logic [31:0] I_LNOP  = 32'h00200000;
  localparam logic [31:0] I_NOP   = 32'h40200000;

  dual_issue_route #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stop_and_signal(stop_and_signal),
    .branch_taken(branch_taken), .hazard_stall(hazard_stall),
    .fetch_valid(fetch_valid), .instr1(instr1), .instr2(instr2),
    .dep_stall_instr1(dep_stall_instr1), .dep_stall_instr2(dep_stall_instr2),
    .even_instr(even_instr), .even_valid(even_valid),
    .odd_instr(odd_instr), .odd_valid(odd_valid), .dual_count(dual_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Instruction kinds, with little-endian field view: RT=[6:0] RA=[13:7] RB=[20:14]
  localparam int K_UNK = 0, K_A = 1, K_SF = 2, K_OR = 3, K_LQX = 4, K_NOP = 5,
                 K_LNOP = 6, K_LQD = 7, K_STQD = 8, K_AI = 9, K_SELB = 10;

  function automatic int kind_of(input logic [31:0] w);
    if (w[31:28] == 4'h8) return K_SELB;
    if (w[31:24] == 8'h34) return K_LQD;
    if (w[31:24] == 8'h24) return K_STQD;
    if (w[31:24] == 8'h1C) return K_AI;
    case (w[31:21])
      11'h0C0: return K_A;
      11'h040: return K_SF;
      11'h041: return K_OR;
      11'h1C4: return K_LQX;
      11'h201: return K_NOP;
      11'h001: return K_LNOP;
      default: return K_UNK;
    endcase
  endfunction

  function automatic bit is_odd(input logic [31:0] w);
    int k = kind_of(w);
    return (k == K_LNOP) || (k == K_LQX) || (k == K_LQD) || (k == K_STQD);
  endfunction

  function automatic bit has_dest(input logic [31:0] w);
    int k = kind_of(w);
    return !((k == K_UNK) || (k == K_NOP) || (k == K_LNOP) || (k == K_STQD));
  endfunction

  function automatic logic [6:0] dest(input logic [31:0] w);
    return (kind_of(w) == K_SELB) ? w[27:21] : w[6:0];
  endfunction

  function automatic bit reads_reg(input logic [31:0] w, input logic [6:0] r);
    int k = kind_of(w);
    logic [6:0] ra = w[13:7], rb = w[20:14], rc = w[6:0];
    if (k == K_A || k == K_SF || k == K_OR || k == K_LQX) return (r == ra) || (r == rb);
    if (k == K_AI || k == K_LQD) return r == ra;
    if (k == K_STQD) return (r == ra) || (r == rc);
    if (k == K_SELB) return (r == ra) || (r == rb) || (r == rc);
    return 1'b0;
  endfunction

  function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
    if (is_odd(a) || !is_odd(b)) return 1'b0;
    return !(has_dest(a) && reads_reg(b, dest(a)));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ra = 7'($urandom_range(0, 7));
    logic [6:0] rb = 7'($urandom_range(0, 7));
    logic [6:0] rt = 7'($urandom_range(0, 7));
    logic [9:0] im = 10'($urandom_range(0, 1023));
    case ($urandom_range(0, 9))
      0: return {11'h0C0, rb, ra, rt};
      1: return {11'h040, rb, ra, rt};
      2: return {11'h041, rb, ra, rt};
      3: return {11'h1C4, rb, ra, rt};
      4: return {11'h201, 21'h0};
      5: return {11'h001, 21'h0};
      6: return {8'h34, im, ra, rt};
      7: return {8'h24, im, ra, rt};
      8: return {8'h1C, im, ra, rt};
      default: return {4'h8, rt, rb, ra, 7'($urandom_range(0, 7))};
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue_one(input logic [31:0] x);
    e_ev_v = !is_odd(x);
    e_od_v = is_odd(x);
    if (is_odd(x)) e_od = x;
    else           e_ev = x;
  endtask

  // Drive one cycle of inputs, check stalls combinationally and slots after the edge
  task automatic step(input bit br, input bit st, input bit hz, input bit fv,
                      input logic [31:0] a, input logic [31:0] b);
    branch_taken = br; stop_and_signal = st; hazard_stall = hz;
    fetch_valid = fv; instr1 = a; instr2 = b;
    e_s1 = !br && (st || hz);
    e_s2 = !br && (st || hz || (!m_split && fv && !pair_ok(a, b)));
    #1;
    cmp("dep_stall_instr1", 32'(dep_stall_instr1), 32'(e_s1));
    cmp("dep_stall_instr2", 32'(dep_stall_instr2), 32'(e_s2));
    if (br) begin
      e_ev_v = 1'b0; e_od_v = 1'b0; m_split = 1'b0;
    end else if (st || hz) begin
      e_ev_v = 1'b0; e_od_v = 1'b0;
    end else if (m_split) begin
      issue_one(m_held); m_split = 1'b0;
    end else if (fv && pair_ok(a, b)) begin
      e_ev = a; e_od = b; e_ev_v = 1'b1; e_od_v = 1'b1; e_cnt = e_cnt + 32'd1;
    end else if (fv) begin
      issue_one(a); m_held = b; m_split = 1'b1;
    end else begin
      e_ev_v = 1'b0; e_od_v = 1'b0;
    end
    last_stall = e_s1 || e_s2;
    @(posedge clk);
    #1;
    cmp("even_valid", 32'(even_valid), 32'(e_ev_v));
    cmp("odd_valid",  32'(odd_valid),  32'(e_od_v));
    cmp("dual_count", dual_count, e_cnt);
    if (e_ev_v) cmp("even_instr", even_instr, e_ev);
    if (e_od_v) cmp("odd_instr",  odd_instr,  e_od);
  endtask

  logic [31:0] p1, p2;

  initial begin
    reset = 1'b1; stop_and_signal = 1'b0; branch_taken = 1'b0;
    hazard_stall = 1'b0; fetch_valid = 1'b0; instr1 = '0; instr2 = '0;
    e_ev_v = 1'b0; e_od_v = 1'b0; e_ev = '0; e_od = '0; e_cnt = '0; last_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset even_instr", even_instr, 32'h0);
    cmp("reset odd_instr",  odd_instr,  32'h0);
    cmp("reset even_valid", 32'(even_valid), 32'h0);
    cmp("reset odd_valid",  32'(odd_valid),  32'h0);
    cmp("reset dual_count", dual_count, 32'h0);
    reset = 1'b0;

    // dual issue of a / lqd
    step(0, 0, 0, 1, I_A3, I_LQD5);
    cmp("pin dual even_instr", even_instr, 32'h18008083);
    cmp("pin dual odd_instr",  odd_instr,  32'h34000205);
    cmp("pin dual count", dual_count, 32'd1);

    // RAW on $3 splits the pair
    step(0, 0, 0, 1, I_A3, I_LQD53);
    cmp("pin raw odd_valid N+1", 32'(odd_valid), 32'd0);
    step(0, 0, 0, 1, I_A3, I_LQD53);
    cmp("pin raw odd_instr N+2", odd_instr, 32'h34000185);
    cmp("pin raw even_valid N+2", 32'(even_valid), 32'd0);
    cmp("pin raw count", dual_count, 32'd1);

    // lnop/nop in the wrong order splits
    step(0, 0, 0, 1, I_LNOP, I_NOP);
    cmp("pin lnop odd slot", odd_instr, 32'h00200000);
    step(0, 0, 0, 1, I_LNOP, I_NOP);
    cmp("pin nop even slot", even_instr, 32'h40200000);

    // branch during SPLIT abandons the held instruction
    step(0, 0, 0, 1, I_A3, I_LQD53);
    step(1, 0, 0, 1, I_A3, I_LQD53);
    cmp("pin branch odd_valid", 32'(odd_valid), 32'd0);
    step(0, 0, 0, 0, '0, '0);

    // hazard stall holds a dual-issuable pair for three cycles
    repeat (3) step(0, 0, 1, 1, I_A3, I_LQD5);
    step(0, 0, 0, 1, I_A3, I_LQD5);
    cmp("pin hazard release count", dual_count, 32'd2);

    // stop_and_signal mid-SPLIT
    step(0, 0, 0, 1, I_A3, I_LQD53);
    repeat (2) step(0, 1, 0, 1, I_A3, I_LQD53);
    step(0, 0, 0, 1, I_A3, I_LQD53);
    cmp("pin stop held odd_instr", odd_instr, 32'h34000185);
    cmp("pin stop count", dual_count, 32'd2);

    // randomized traffic; fetch holds its pair while the model expects a stall
    last_stall = 1'b0;
    p1 = rand_instr(); p2 = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      bit br, st, hz, fv;
      br = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 3);
      hz = ($urandom_range(0, 99) < 8);
      fv = ($urandom_range(0, 99) < 90);
      step(br, st, hz, fv, p1, p2);
      if (!last_stall) begin
        p1 = rand_instr(); p2 = rand_instr();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
